// File: rtl/mips_dbus.sv
`default_nettype none
// ============================================================================
// Module   : mips_dbus
// Purpose  : Data-bus bridge between the single-cycle MIPS core and a
//            variable-latency data memory. The core's zero-wait load/store
//            port becomes a req/ack handshake. While a transfer is
//            outstanding, the core's enable is withheld so PC and register
//            file stay frozen. A programmable timeout aborts a hung transfer
//            and sets a sticky error flag. A saturating counter records
//            stalled cycles.
//
// Ports    : clk          in   system clock, rising edge
//            reset        in   synchronous active-high reset
//            enable_in    in   global run enable from the top level
//            core_enable  out  enable into the core (combinational)
//            core_rd      in   current instruction is a load
//            core_wr      in   current instruction is a store (wins over rd)
//            core_addr    in   byte address from the core
//            core_wdata   in   store data from the core
//            core_rdata   out  load data to the core (combinational)
//            bus_req      out  registered transfer request
//            bus_we       out  registered write flag
//            bus_addr     out  registered address
//            bus_wdata    out  registered write data
//            bus_ack      in   one-cycle completion pulse
//            bus_rdata    in   read data, valid with bus_ack
//            err          out  sticky timeout flag
//            stall_cnt    out  saturating count of stalled cycles
//
// Revision : 1.0  initial release
// ============================================================================
module mips_dbus #(
    parameter int          wordsize = 32,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable_in,
    output logic                core_enable,
    input  logic                core_rd,
    input  logic                core_wr,
    input  logic [wordsize-1:0] core_addr,
    input  logic [wordsize-1:0] core_wdata,
    output logic [wordsize-1:0] core_rdata,
    output logic                bus_req,
    output logic                bus_we,
    output logic [wordsize-1:0] bus_addr,
    output logic [wordsize-1:0] bus_wdata,
    input  logic                bus_ack,
    input  logic [wordsize-1:0] bus_rdata,
    output logic                err,
    output logic [31:0]         stall_cnt
);

    // Counter wide enough to hold TIMEOUT-1 (the last WAIT cycle index).
    localparam int                  C_CW        = $clog2(TIMEOUT + 1);
    localparam logic [C_CW-1:0]     C_WAIT_LAST = C_CW'(TIMEOUT - 1);
    localparam logic [C_CW-1:0]     C_CNT_ONE   = C_CW'(1);
    localparam logic [wordsize-1:0] C_ERR_DATA  = wordsize'(ERR_DATA);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [wordsize-1:0] r_rdata_q;
    logic [C_CW-1:0]     r_wait_cnt;
    logic                r_bus_req;
    logic                r_bus_we;
    logic [wordsize-1:0] r_bus_addr;
    logic [wordsize-1:0] r_bus_wdata;
    logic                r_err;
    logic [31:0]         r_stall_cnt;

    logic                w_mem_op;
    logic                w_launch;
    logic                w_core_enable;
    logic [wordsize-1:0] w_core_rdata;
    logic                w_stall;

    assign w_mem_op = core_rd | core_wr;
    assign w_launch = (r_state == S_IDLE) & enable_in & w_mem_op;

    // In IDLE a pending memory instruction must not commit yet, so the
    // enable is masked; in DONE the captured data is presented for commit.
    always_comb begin
        w_core_enable = 1'b0;
        w_core_rdata  = '0;
        case (r_state)
            S_IDLE: begin
                w_core_enable = enable_in & ~w_mem_op;
            end
            S_DONE: begin
                w_core_enable = enable_in;
                w_core_rdata  = r_rdata_q;
            end
            default: begin
                w_core_enable = 1'b0;
                w_core_rdata  = '0;
            end
        endcase
    end

    // Only cycles the outside world wanted to run count as stalls.
    assign w_stall = enable_in & ~w_core_enable;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_rdata_q   <= '0;
            r_wait_cnt  <= '0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_err       <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_bus_addr  <= core_addr;
                        r_bus_wdata <= core_wdata;
                        r_bus_we    <= core_wr;
                        r_bus_req   <= 1'b1;
                        r_wait_cnt  <= '0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // An ack on the final allowed cycle still wins over the
                    // timeout, so bus_req is high for at most TIMEOUT cycles.
                    if (bus_ack) begin
                        r_rdata_q  <= bus_rdata;
                        r_wait_cnt <= '0;
                        r_bus_req  <= 1'b0;
                        r_state    <= S_DONE;
                    end else if (r_wait_cnt == C_WAIT_LAST) begin
                        r_rdata_q  <= C_ERR_DATA;
                        r_err      <= 1'b1;
                        r_wait_cnt <= '0;
                        r_bus_req  <= 1'b0;
                        r_state    <= S_DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + C_CNT_ONE;
                    end
                end
                S_DONE: begin
                    // The core commits in the first enabled DONE cycle.
                    if (enable_in) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_bus_req <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign core_enable = w_core_enable;
    assign core_rdata  = w_core_rdata;
    assign bus_req     = r_bus_req;
    assign bus_we      = r_bus_we;
    assign bus_addr    = r_bus_addr;
    assign bus_wdata   = r_bus_wdata;
    assign err         = r_err;
    assign stall_cnt   = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mips_dbus.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_dbus
// Purpose  : Cycle-by-cycle vector bench for mips_dbus (TIMEOUT = 4).
//            Each vector holds the inputs for one clock cycle and the
//            outputs expected during that cycle, before the rising edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_mips_dbus;

    logic        clk;
    logic        reset;
    logic        enable_in;
    logic        core_enable;
    logic        core_rd;
    logic        core_wr;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [31:0] core_rdata;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        err;
    logic [31:0] stall_cnt;

    int n_vec;
    int n_bad;

    mips_dbus #(
        .wordsize (32),
        .TIMEOUT  (4),
        .ERR_DATA (32'hDEAD_BEEF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable_in   (enable_in),
        .core_enable (core_enable),
        .core_rd     (core_rd),
        .core_wr     (core_wr),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_rdata  (core_rdata),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata),
        .err         (err),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic        rd;
        logic        wr;
        logic        ack;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] brdata;
        logic        e_ce;
        logic [31:0] e_rdata;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_baddr;
        logic [31:0] e_bwdata;
        logic        e_err;
        logic [31:0] e_stall;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, input logic en, input logic rd, input logic wr,
                       input logic ack, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] brdata, input logic e_ce, input logic [31:0] e_rdata,
                       input logic e_req, input logic e_we, input logic [31:0] e_baddr,
                       input logic [31:0] e_bwdata, input logic e_err, input logic [31:0] e_stall);
        vec_t v;
        v.rst = rst; v.en = en; v.rd = rd; v.wr = wr; v.ack = ack;
        v.addr = addr; v.wdata = wdata; v.brdata = brdata;
        v.e_ce = e_ce; v.e_rdata = e_rdata; v.e_req = e_req; v.e_we = e_we;
        v.e_baddr = e_baddr; v.e_bwdata = e_bwdata; v.e_err = e_err; v.e_stall = e_stall;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @vec %0d: got %h, want %h", name, idx, act, exp);
        end
    endtask

    int req_cycles;
    int low_cycles;
    bit done_seen;

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset = 1'b1; enable_in = 1'b0; core_rd = 1'b0; core_wr = 1'b0;
        core_addr = '0; core_wdata = '0; bus_ack = 1'b0; bus_rdata = '0;

        //   rst en rd wr ack addr          wdata         brdata        | ce rdata         req we baddr         bwdata        err stall
        // reset held, then ALU-only instructions
        add(1, 1, 0, 0, 0, 32'h0000_0055, 32'h0000_0066, 32'h0,        1, 32'h0,         0, 0, 32'h0,         32'h0,         0, 0);
        add(0, 1, 0, 0, 0, 32'h0000_0055, 32'h0000_0066, 32'h0,        1, 32'h0,         0, 0, 32'h0,         32'h0,         0, 0);
        add(0, 1, 0, 0, 0, 32'h0000_0055, 32'h0000_0066, 32'h0,        1, 32'h0,         0, 0, 32'h0,         32'h0,         0, 0);
        // load at 0x40, ack one cycle after req
        add(0, 1, 1, 0, 0, 32'h0000_0040, 32'h0000_0077, 32'h0,        0, 32'h0,         0, 0, 32'h0,         32'h0,         0, 0);
        add(0, 1, 1, 0, 0, 32'h0000_0040, 32'h0000_0077, 32'h0,        0, 32'h0,         1, 0, 32'h0000_0040, 32'h0000_0077, 0, 1);
        add(0, 1, 1, 0, 1, 32'h0000_0040, 32'h0000_0077, 32'h1234_5678, 0, 32'h0,        1, 0, 32'h0000_0040, 32'h0000_0077, 0, 2);
        add(0, 1, 1, 0, 0, 32'h0000_0040, 32'h0000_0077, 32'h0,        1, 32'h1234_5678, 0, 0, 32'h0000_0040, 32'h0000_0077, 0, 3);
        add(0, 1, 0, 0, 0, 32'h0000_0055, 32'h0000_0066, 32'h0,        1, 32'h0,         0, 0, 32'h0000_0040, 32'h0000_0077, 0, 3);
        // store of 0xCAFEF00D to 0x100, ack in first WAIT cycle
        add(0, 1, 0, 1, 0, 32'h0000_0100, 32'hCAFE_F00D, 32'h0,        0, 32'h0,         0, 0, 32'h0000_0040, 32'h0000_0077, 0, 3);
        add(0, 1, 0, 1, 1, 32'h0000_0100, 32'hCAFE_F00D, 32'hAAAA_0000, 0, 32'h0,        1, 1, 32'h0000_0100, 32'hCAFE_F00D, 0, 4);
        add(0, 1, 0, 1, 0, 32'h0000_0100, 32'hCAFE_F00D, 32'h0,        1, 32'hAAAA_0000, 0, 1, 32'h0000_0100, 32'hCAFE_F00D, 0, 5);
        // back-to-back load at 0x200
        add(0, 1, 1, 0, 0, 32'h0000_0200, 32'h0,         32'h0,        0, 32'h0,         0, 1, 32'h0000_0100, 32'hCAFE_F00D, 0, 5);
        add(0, 1, 1, 0, 1, 32'h0000_0200, 32'h0,         32'h0BAD_F00D, 0, 32'h0,        1, 0, 32'h0000_0200, 32'h0,         0, 6);
        add(0, 1, 1, 0, 0, 32'h0000_0200, 32'h0,         32'h0,        1, 32'h0BAD_F00D, 0, 0, 32'h0000_0200, 32'h0,         0, 7);
        // load at 0x300 with no ack: timeout after 4 WAIT cycles
        add(0, 1, 1, 0, 0, 32'h0000_0300, 32'h0000_0011, 32'h0,        0, 32'h0,         0, 0, 32'h0000_0200, 32'h0,         0, 7);
        add(0, 1, 1, 0, 0, 32'h0000_0300, 32'h0000_0011, 32'h0,        0, 32'h0,         1, 0, 32'h0000_0300, 32'h0000_0011, 0, 8);
        add(0, 1, 1, 0, 0, 32'h0000_0300, 32'h0000_0011, 32'h0,        0, 32'h0,         1, 0, 32'h0000_0300, 32'h0000_0011, 0, 9);
        add(0, 1, 1, 0, 0, 32'h0000_0300, 32'h0000_0011, 32'h0,        0, 32'h0,         1, 0, 32'h0000_0300, 32'h0000_0011, 0, 10);
        add(0, 1, 1, 0, 0, 32'h0000_0300, 32'h0000_0011, 32'h0,        0, 32'h0,         1, 0, 32'h0000_0300, 32'h0000_0011, 0, 11);
        add(0, 1, 1, 0, 0, 32'h0000_0300, 32'h0000_0011, 32'h0,        1, 32'hDEAD_BEEF, 0, 0, 32'h0000_0300, 32'h0000_0011, 1, 12);
        // ALU cycles, late ack two cycles after commit is ignored
        add(0, 1, 0, 0, 0, 32'h0000_0055, 32'h0000_0066, 32'h0,        1, 32'h0,         0, 0, 32'h0000_0300, 32'h0000_0011, 1, 12);
        add(0, 1, 0, 0, 1, 32'h0000_0055, 32'h0000_0066, 32'h9999_9999, 1, 32'h0,        0, 0, 32'h0000_0300, 32'h0000_0011, 1, 12);
        add(0, 1, 0, 0, 0, 32'h0000_0055, 32'h0000_0066, 32'h0,        1, 32'h0,         0, 0, 32'h0000_0300, 32'h0000_0011, 1, 12);
        // load at 0x400, enable_in dropped in WAIT, DONE held until it returns
        add(0, 1, 1, 0, 0, 32'h0000_0400, 32'h0000_0022, 32'h0,        0, 32'h0,         0, 0, 32'h0000_0300, 32'h0000_0011, 1, 12);
        add(0, 0, 1, 0, 0, 32'h0000_0400, 32'h0000_0022, 32'h0,        0, 32'h0,         1, 0, 32'h0000_0400, 32'h0000_0022, 1, 13);
        add(0, 0, 1, 0, 1, 32'h0000_0400, 32'h0000_0022, 32'h5A5A_5A5A, 0, 32'h0,        1, 0, 32'h0000_0400, 32'h0000_0022, 1, 13);
        add(0, 0, 1, 0, 0, 32'h0000_0400, 32'h0000_0022, 32'h0,        0, 32'h5A5A_5A5A, 0, 0, 32'h0000_0400, 32'h0000_0022, 1, 13);
        add(0, 0, 1, 0, 1, 32'h0000_0400, 32'h0000_0022, 32'hFFFF_FFFF, 0, 32'h5A5A_5A5A, 0, 0, 32'h0000_0400, 32'h0000_0022, 1, 13);
        add(0, 1, 1, 0, 0, 32'h0000_0400, 32'h0000_0022, 32'h0,        1, 32'h5A5A_5A5A, 0, 0, 32'h0000_0400, 32'h0000_0022, 1, 13);
        add(0, 1, 0, 0, 0, 32'h0000_0055, 32'h0000_0066, 32'h0,        1, 32'h0,         0, 0, 32'h0000_0400, 32'h0000_0022, 1, 13);
        // load at 0x500, reset pulsed in the second WAIT cycle, stray ack after
        add(0, 1, 1, 0, 0, 32'h0000_0500, 32'h0000_0033, 32'h0,        0, 32'h0,         0, 0, 32'h0000_0400, 32'h0000_0022, 1, 13);
        add(0, 1, 1, 0, 0, 32'h0000_0500, 32'h0000_0033, 32'h0,        0, 32'h0,         1, 0, 32'h0000_0500, 32'h0000_0033, 1, 14);
        add(1, 1, 1, 0, 0, 32'h0000_0500, 32'h0000_0033, 32'h0,        0, 32'h0,         1, 0, 32'h0000_0500, 32'h0000_0033, 1, 15);
        add(0, 1, 0, 0, 1, 32'h0000_0055, 32'h0000_0066, 32'h7777_7777, 1, 32'h0,        0, 0, 32'h0,         32'h0,         0, 0);
        add(0, 1, 0, 0, 0, 32'h0000_0055, 32'h0000_0066, 32'h0,        1, 32'h0,         0, 0, 32'h0,         32'h0,         0, 0);
        // rd and wr both high is a write
        add(0, 1, 1, 1, 0, 32'h0000_0600, 32'h0000_0044, 32'h0,        0, 32'h0,         0, 0, 32'h0,         32'h0,         0, 0);
        add(0, 1, 1, 1, 1, 32'h0000_0600, 32'h0000_0044, 32'h0000_0001, 0, 32'h0,        1, 1, 32'h0000_0600, 32'h0000_0044, 0, 1);
        add(0, 1, 1, 1, 0, 32'h0000_0600, 32'h0000_0044, 32'h0,        1, 32'h0000_0001, 0, 1, 32'h0000_0600, 32'h0000_0044, 0, 2);
        // enable_in low in IDLE never launches and is not a stall
        add(0, 0, 1, 0, 0, 32'h0000_0700, 32'h0000_0055, 32'h0,        0, 32'h0,         0, 1, 32'h0000_0600, 32'h0000_0044, 0, 2);
        add(0, 0, 0, 0, 0, 32'h0000_0055, 32'h0000_0066, 32'h0,        0, 32'h0,         0, 1, 32'h0000_0600, 32'h0000_0044, 0, 2);

        repeat (2) @(posedge clk);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            reset      = vq[i].rst;
            enable_in  = vq[i].en;
            core_rd    = vq[i].rd;
            core_wr    = vq[i].wr;
            bus_ack    = vq[i].ack;
            core_addr  = vq[i].addr;
            core_wdata = vq[i].wdata;
            bus_rdata  = vq[i].brdata;
            #1;
            n_vec++;
            chk("core_enable", i, {31'b0, core_enable}, {31'b0, vq[i].e_ce});
            chk("core_rdata",  i, core_rdata,           vq[i].e_rdata);
            chk("bus_req",     i, {31'b0, bus_req},     {31'b0, vq[i].e_req});
            chk("bus_we",      i, {31'b0, bus_we},      {31'b0, vq[i].e_we});
            chk("bus_addr",    i, bus_addr,             vq[i].e_baddr);
            chk("bus_wdata",   i, bus_wdata,            vq[i].e_bwdata);
            chk("err",         i, {31'b0, err},         {31'b0, vq[i].e_err});
            chk("stall_cnt",   i, stall_cnt,            vq[i].e_stall);
        end

        // Hand-written timeout sequence with a bounded wait: hold a load
        // with no ack until the core is enabled again.
        @(negedge clk);
        reset = 1'b0; enable_in = 1'b1; core_rd = 1'b1; core_wr = 1'b0;
        core_addr = 32'h0000_0800; core_wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
        req_cycles = 0;
        low_cycles = 0;
        done_seen  = 1'b0;
        for (int c = 0; c < 20 && !done_seen; c++) begin
            #1;
            if (bus_req) req_cycles++;
            if (core_enable) done_seen = 1'b1;
            else begin
                low_cycles++;
                @(negedge clk);
            end
        end
        n_vec++;
        if (!done_seen) begin
            n_bad++;
            $display("FAIL timeout_commit: core_enable never returned within 20 cycles, want 1");
        end
        chk("timeout_req_cycles",  -1, 32'(req_cycles), 32'd4);
        chk("timeout_stall_cycles", -1, 32'(low_cycles), 32'd5);
        chk("timeout_err",         -1, {31'b0, err},   32'd1);
        chk("timeout_rdata",       -1, core_rdata,     32'hDEAD_BEEF);
        chk("timeout_stall_cnt",   -1, stall_cnt,      32'd7);
        chk("timeout_addr",        -1, bus_addr,       32'h0000_0800);

        @(negedge clk);
        core_rd = 1'b0;
        #1;
        n_vec++;
        chk("post_timeout_ce",    -1, {31'b0, core_enable}, 32'd1);
        chk("post_timeout_rdata", -1, core_rdata,           32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_dbus.md
# mips_dbus

Data-bus interface between the single-cycle MIPS core and a variable-latency data memory. It converts the core's zero-wait load/store port into a req/ack handshake. While a transfer is outstanding it withholds the core's enable, so the core stalls with PC and register file frozen. It also adds a programmable timeout with a sticky error flag and a saturating stall-cycle counter. It sits in the top level, between the core's memory outputs, the core's enable input and the data memory.

## Interface
Parameters:
- wordsize, 32, width of address and data buses.
- TIMEOUT, 255, maximum cycles to wait for bus_ack before aborting; must be ≥1.
- ERR_DATA, 32'hDEAD_BEEF, read data returned to the core on a timed-out load (truncated to wordsize).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable_in  in  1  global run enable from the tester/top.
- core_enable  out  1  enable driven into the core (PC/register-file update).
- core_rd  in  1  current instruction is a load.
- core_wr  in  1  current instruction is a store.
- core_addr  in  wordsize  byte address from the core.
- core_wdata  in  wordsize  store data from the core.
- core_rdata  out  wordsize  load data returned to the core.
- bus_req  out  1  transfer request to memory.
- bus_we  out  1  1 = write, 0 = read; valid while bus_req is high.
- bus_addr  out  wordsize  registered address; stable while bus_req is high.
- bus_wdata  out  wordsize  registered write data; stable while bus_req is high.
- bus_ack  in  1  one-cycle completion pulse from memory.
- bus_rdata  in  wordsize  read data, valid in the bus_ack cycle.
- err  out  1  sticky timeout flag.
- stall_cnt  out  32  saturating count of cycles in which the core was stalled.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - With core_rd|core_wr low: core_enable = enable_in; core_rdata = 0.
  - With enable_in & (core_rd|core_wr):
    - core_enable = 0.
    - Register bus_addr = core_addr, bus_wdata = core_wdata, bus_we = core_wr.
    - Next state WAIT. bus_req goes high from the next cycle.
  - If core_rd and core_wr are both high, the access is a write.
- WAIT:
  - bus_req = 1; core_enable = 0.
  - bus_addr, bus_wdata and bus_we hold their values.
  - wait_cnt increments every cycle.
  - On bus_ack: rdata_q ← bus_rdata (writes also capture, value ignored), wait_cnt cleared, next state DONE.
  - If wait_cnt reaches TIMEOUT with no ack:
    - rdata_q ← ERR_DATA, err ← 1, next state DONE.
    - bus_req drops; a late bus_ack in any later state is ignored.
  - enable_in low in WAIT does not abort the transfer; the request continues.
- DONE:
  - bus_req = 0; core_rdata = rdata_q; core_enable = enable_in.
  - The core commits the load/store instruction in the first DONE cycle with enable_in = 1.
  - Leave for IDLE in that cycle. If enable_in = 0, remain in DONE.
  - DONE never launches a new request. The following instruction is evaluated in IDLE.
- stall_cnt: increments in every cycle where enable_in = 1 and core_enable = 0. It saturates at 32'hFFFF_FFFF.
- err and stall_cnt clear only on reset.

## Timing
- Reset values:
  - State IDLE; bus_req = 0, bus_we = 0, bus_addr = 0, bus_wdata = 0.
  - rdata_q = 0, wait_cnt = 0, err = 0, stall_cnt = 0.
  - core_enable follows enable_in combinationally, since the state is IDLE.
- Minimum load/store cost is 3 cycles:
  - Cycle 0: IDLE, request detected.
  - Cycle 1: WAIT, bus_req high, memory acks in the same cycle.
  - Cycle 2: DONE, commit.
  - An ack arriving k cycles after bus_req rises costs 3+k cycles.
- Timeout abort: DONE is entered on the cycle after TIMEOUT WAIT cycles, i.e. bus_req is high for exactly TIMEOUT cycles.
- Non-memory instructions add zero cycles.
- Outputs:
  - bus_* are registered.
  - core_enable and core_rdata are combinational from state and enable_in.
- Reset asserted mid-transfer: the next cycle is IDLE with bus_req = 0, and the in-flight ack is ignored. Memory must tolerate a dropped request.
- A bus_ack in IDLE or DONE is ignored and has no side effects.

## Test plan
- Reset, then enable_in = 1 with an ALU-only instruction:
  - core_enable = 1 every cycle, bus_req never asserted, stall_cnt = 0.
- Load at 0x0000_0040, memory acks 1 cycle after req with bus_rdata = 0x1234_5678:
  - bus_req high for 2 cycles, bus_we = 0.
  - core_enable low for 3 cycles, then core_rdata = 0x1234_5678 with core_enable = 1.
  - stall_cnt = 3.
- Store of 0xCAFE_F00D to 0x0000_0100, ack in the first WAIT cycle:
  - bus_we = 1, bus_addr and bus_wdata stable while bus_req is high.
  - Commit in the next cycle.
  - A back-to-back following load starts a new request from IDLE.
- TIMEOUT = 4, no ack:
  - bus_req high exactly 4 cycles, err = 1, core_rdata = 0xDEAD_BEEF at commit.
  - A late ack 2 cycles later changes nothing.
- enable_in dropped in WAIT and ack received:
  - FSM holds DONE until enable_in returns, then commits the captured data.
  - stall_cnt does not count the enable_in = 0 cycles.
- reset pulsed in the second WAIT cycle:
  - Next cycle IDLE with bus_req = 0, err = 0, stall_cnt = 0.
  - A subsequent ack is ignored.
